// File: rtl/mb8_arbiter_pkg.sv
// Shared definitions for the 8-bit memory block arbiter: FSM states and
// the fixed requester numbering used by the outer interpreter.
package mb8_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    YIELD = 2'd2
  } arb_sts;

  localparam int RQ_FDR = 0;
  localparam int RQ_A2I = 1;
  localparam int RQ_EXE = 2;
  localparam int RQ_CMA = 3;

endpackage

// File: rtl/mb8_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled.
// slave is the arbiter view; master is the requesters-plus-memory view.
interface mb8_arbiter_if
  import mb8_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MSZ  = 8,
  parameter int ASZ  = 17,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     we;
  logic [NREQ*ASZ-1:0] ai;
  logic [NREQ*MSZ-1:0] vi;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rv;
  logic [MSZ-1:0]      vo;
  logic                mem_we;
  logic [ASZ-1:0]      mem_ai;
  logic [MSZ-1:0]      mem_vi;
  logic [MSZ-1:0]      mem;
  logic [IDW-1:0]      owner;
  logic                bsy;

  modport slave (
    input  req, we, ai, vi, mem,
    output gnt, rv, vo, mem_we, mem_ai, mem_vi, owner, bsy
  );

  modport master (
    output req, we, ai, vi, mem,
    input  gnt, rv, vo, mem_we, mem_ai, mem_vi, owner, bsy
  );
endinterface

// File: rtl/mb8_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req after ptr, wrapping.
module mb8_arbiter_rr_pick
  import mb8_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any
);

  // Scan from farthest to nearest so the nearest set request wins last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IDW'((int'(ptr) + k) % NREQ)]) begin
        win = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mb8_arbiter.sv
// Round-robin burst arbiter sharing one synchronous-read memory port,
// with optional hold limit and read-data return to the issuing requester.
module mb8_arbiter
  import mb8_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MSZ  = 8,
  parameter int ASZ  = 17,
  parameter int HOLD = 0,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  mb8_arbiter_if.slave  bus
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  arb_sts          state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] rv_reg;
  logic [IDW-1:0]  owner_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [CW-1:0]   cnt_reg;

  logic [IDW-1:0]  win;
  logic            any;
  logic [NREQ-1:0] own_oh;
  logic            own_req;
  logic            commit;
  logic            others;
  logic            hold_hit;

  logic [ASZ-1:0]  ai_arr [NREQ];
  logic [MSZ-1:0]  vi_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign ai_arr[gi] = bus.ai[gi*ASZ +: ASZ];
      assign vi_arr[gi] = bus.vi[gi*MSZ +: MSZ];
    end
  endgenerate

  mb8_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (ptr_reg),
    .win (win),
    .any (any)
  );

  assign own_oh   = NREQ'(1) << owner_reg;
  assign own_req  = |(bus.req & own_oh);
  assign commit   = (|(gnt_reg & own_oh)) & own_req;
  assign others   = |(bus.req & ~own_oh);
  assign hold_hit = (HOLD > 0) && (cnt_reg == CW'(HOLD - 1));

  // The write strobe is gated by rst so a reset mid-burst never writes.
  assign bus.mem_we = ~rst & commit & bus.we[owner_reg];
  assign bus.mem_ai = (|gnt_reg) ? ai_arr[owner_reg] : '0;
  assign bus.mem_vi = (|gnt_reg) ? vi_arr[owner_reg] : '0;
  assign bus.vo     = bus.mem;
  assign bus.gnt    = gnt_reg;
  assign bus.rv     = rv_reg;
  assign bus.owner  = owner_reg;
  assign bus.bsy    = |gnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      rv_reg    <= '0;
      owner_reg <= '0;
      ptr_reg   <= IDW'(NREQ - 1);
      cnt_reg   <= '0;
    end else begin
      rv_reg <= (commit && !bus.we[owner_reg]) ? own_oh : '0;
      case (state_reg)
        OWN: begin
          if (!own_req) begin
            // Owner released: hand over with no dead cycle if anyone waits.
            if (any) begin
              gnt_reg   <= NREQ'(1) << win;
              owner_reg <= win;
              ptr_reg   <= win;
              cnt_reg   <= '0;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
            end
          end else if (hold_hit && others) begin
            state_reg <= YIELD;
            gnt_reg   <= '0;
          end else if (HOLD > 0 && !hold_hit) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          if (any) begin
            state_reg <= OWN;
            gnt_reg   <= NREQ'(1) << win;
            owner_reg <= win;
            ptr_reg   <= win;
            cnt_reg   <= '0;
          end else begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb8_arbiter.sv
// Directed bench for mb8_arbiter: two instances (HOLD=0 and HOLD=4) driven by
// the same stimulus, each compared every cycle against a behavioural model.
module tb_mb8_arbiter;
  import mb8_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, we;
  logic [67:0] ai;
  logic [31:0] vi;
  logic [7:0]  mem0, mem4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mb8_arbiter_if #(.NREQ(4), .MSZ(8), .ASZ(17)) if0 ();
  mb8_arbiter_if #(.NREQ(4), .MSZ(8), .ASZ(17)) if4 ();

  mb8_arbiter #(.NREQ(4), .MSZ(8), .ASZ(17), .HOLD(0)) d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mb8_arbiter #(.NREQ(4), .MSZ(8), .ASZ(17), .HOLD(4)) d4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if0.req = req;  assign if4.req = req;
  assign if0.we  = we;   assign if4.we  = we;
  assign if0.ai  = ai;   assign if4.ai  = ai;
  assign if0.vi  = vi;   assign if4.vi  = vi;
  assign if0.mem = mem0; assign if4.mem = mem4;

  // Memory whose content at each address is the address low byte.
  always @(posedge clk) begin
    mem0 <= if0.mem_ai[7:0];
    mem4 <= if4.mem_ai[7:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int hv[2]     = '{0, 4};
  int m_own[2];   // granted requester, -1 when nobody holds the port
  int m_last[2];
  int m_ptr[2];
  int m_run[2];
  int m_rv[2];    // requester owed read data this cycle, -1 if none
  int m_rvd[2];
  bit started = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [16:0] addr_of(input int i);
    return ai[i*17 +: 17];
  endfunction

  function automatic logic [7:0] data_of(input int i);
    return vi[i*8 +: 8];
  endfunction

  task automatic cmp(input int d, input logic [3:0] g, input logic [3:0] r, input logic [7:0] vo,
                     input logic mwe, input logic [16:0] mai, input logic [7:0] mvi,
                     input logic [1:0] own, input logic b);
    int o;
    logic [3:0] eg, er;
    logic ecommit;
    logic [16:0] eai;
    logic [7:0] evi;
    o = m_own[d];
    eg = '0; ecommit = 1'b0; eai = '0; evi = '0;
    if (o >= 0) begin
      eg = 4'(1 << o);
      ecommit = req[o];
      eai = addr_of(o);
      evi = data_of(o);
    end
    er = (m_rv[d] >= 0) ? 4'(1 << m_rv[d]) : 4'b0;
    chk($sformatf("d%0d gnt", d), 32'(g), 32'(eg));
    chk($sformatf("d%0d rv", d), 32'(r), 32'(er));
    if (er != 0) chk($sformatf("d%0d vo", d), 32'(vo), 32'(m_rvd[d]));
    chk($sformatf("d%0d mem_we", d), 32'(mwe), 32'(!rst && ecommit && we[o < 0 ? 0 : o]));
    chk($sformatf("d%0d mem_ai", d), 32'(mai), 32'(eai));
    chk($sformatf("d%0d mem_vi", d), 32'(mvi), 32'(evi));
    chk($sformatf("d%0d owner", d), 32'(own), 32'(m_last[d]));
    chk($sformatf("d%0d bsy", d), 32'(b), 32'(o >= 0));
  endtask

  task automatic advance(input int d);
    int o, w;
    o = m_own[d];
    if (rst) begin
      m_own[d] = -1; m_last[d] = 0; m_ptr[d] = 3; m_run[d] = 0; m_rv[d] = -1;
      return;
    end
    m_rv[d] = -1;
    if (o >= 0 && req[o] && !we[o]) begin
      m_rv[d] = o;
      m_rvd[d] = int'(addr_of(o) & 17'hFF);
    end
    if (o < 0 || !req[o]) begin
      w = pick(req, m_ptr[d]);
      if (w >= 0) begin
        m_own[d] = w; m_last[d] = w; m_ptr[d] = w; m_run[d] = 0;
      end else begin
        m_own[d] = -1;
      end
    end else if (hv[d] > 0 && m_run[d] >= hv[d] - 1 && (req & ~(4'b1 << o)) != 0) begin
      m_own[d] = -1;
    end else begin
      m_run[d]++;
    end
  endtask

  // Inputs are stable from just after each posedge, so the negedge both
  // checks the current cycle and steps the model across the next edge.
  always @(negedge clk) begin
    if (started) begin
      cmp(0, if0.gnt, if0.rv, if0.vo, if0.mem_we, if0.mem_ai, if0.mem_vi, if0.owner, if0.bsy);
      cmp(1, if4.gnt, if4.rv, if4.vo, if4.mem_we, if4.mem_ai, if4.mem_vi, if4.owner, if4.bsy);
    end
    advance(0);
    advance(1);
    started = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ai(input int i, input logic [16:0] a);
    ai[i*17 +: 17] = a;
  endtask

  logic [3:0] yield_seq [11] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};

  initial begin
    rst = 1'b1; req = '0; we = '0; ai = '0; vi = '0;
    for (int i = 0; i < 4; i++) set_ai(i, 17'(32'h40 + i));
    tick(); tick();
    chk("reset gnt", 32'(if0.gnt), 0);
    chk("reset rv", 32'(if0.rv), 0);
    chk("reset owner", 32'(if0.owner), 0);
    chk("reset bsy", 32'(if0.bsy), 0);
    rst = 1'b0;

    // Release order 0,1,2,3 with everyone requesting.
    req = 4'b1111; tick(); chk("rr gnt0", 32'(if0.gnt), 32'h1);
    $display("txn rr: gnt=%b", if0.gnt);
    req = 4'b1110; tick(); chk("rr gnt1", 32'(if0.gnt), 32'h2);
    $display("txn rr: gnt=%b", if0.gnt);
    req = 4'b1100; tick(); chk("rr gnt2", 32'(if0.gnt), 32'h4);
    $display("txn rr: gnt=%b", if0.gnt);
    req = 4'b1000; tick(); chk("rr gnt3", 32'(if0.gnt), 32'h8);
    $display("txn rr: gnt=%b", if0.gnt);
    req = 4'b0000; tick();
    chk("idle gnt", 32'(if0.gnt), 0);
    chk("idle owner", 32'(if0.owner), 3);

    // Finder burst of 10 reads; atoi waits for the whole burst.
    req[RQ_FDR] = 1'b1; set_ai(RQ_FDR, 17'h00100); tick();
    for (int k = 0; k < 10; k++) begin
      set_ai(RQ_FDR, 17'(32'h100 + k));
      if (k == 3) req[RQ_A2I] = 1'b1;
      tick();
      $display("txn read addr=%05h rv=%b vo=%02h", 32'h100 + k, if0.rv, if0.vo);
      chk("burst rv", 32'(if0.rv), 32'h1);
      chk("burst vo", 32'(if0.vo), 32'(k));
      chk("burst gnt", 32'(if0.gnt), 32'h1);
    end
    req[RQ_FDR] = 1'b0;
    tick();
    chk("handover gnt", 32'(if0.gnt), 32'h2);
    chk("handover rv", 32'(if0.rv), 0);
    req = '0; tick(); tick();

    // Comma write.
    req[RQ_CMA] = 1'b1; we[RQ_CMA] = 1'b1; set_ai(RQ_CMA, 17'h1F000); vi[24 +: 8] = 8'hA5;
    #1 chk("wr ungranted mem_we", 32'(if0.mem_we), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      $display("txn write addr=%05h data=%02h mem_we=%b", if0.mem_ai, if0.mem_vi, if0.mem_we);
      chk("wr mem_we", 32'(if0.mem_we), 1);
      chk("wr mem_ai", 32'(if0.mem_ai), 32'h1F000);
      chk("wr mem_vi", 32'(if0.mem_vi), 32'hA5);
      chk("wr rv", 32'(if0.rv), 0);
    end
    req = '0; we = '0; tick();
    chk("wr after rv", 32'(if0.rv), 0);
    tick();

    // One-cycle pulse: grant arrives as the request vanishes, no access.
    req[RQ_EXE] = 1'b1; tick();
    chk("pulse gnt", 32'(if0.gnt), 32'h4);
    req = '0;
    #1 chk("pulse mem_we", 32'(if0.mem_we), 0);
    tick();
    chk("pulse rv", 32'(if0.rv), 0);
    chk("pulse gnt gone", 32'(if0.gnt), 0);
    $display("txn pulse: gnt=%b rv=%b", if0.gnt, if0.rv);
    tick();

    // Reset in the middle of an atoi write burst.
    req[RQ_A2I] = 1'b1; we[RQ_A2I] = 1'b1; set_ai(RQ_A2I, 17'h00555); vi[8 +: 8] = 8'h3C;
    tick(); tick();
    chk("pre-rst mem_we", 32'(if0.mem_we), 1);
    rst = 1'b1;
    #1 chk("rst cycle mem_we", 32'(if0.mem_we), 0);
    tick();
    chk("post-rst gnt", 32'(if0.gnt), 0);
    chk("post-rst rv", 32'(if0.rv), 0);
    chk("post-rst owner", 32'(if0.owner), 0);
    rst = 1'b0; req[RQ_FDR] = 1'b1; we = '0;
    tick();
    chk("post-rst winner", 32'(if0.gnt), 32'h1);
    $display("txn reset: gnt=%b owner=%0d", if0.gnt, if0.owner);
    req = '0; tick(); tick();

    // Hold limit on the HOLD=4 instance.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0101;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk($sformatf("hold gnt c%0d", k), 32'(if4.gnt), 32'(yield_seq[k]));
      $display("txn hold c%0d: gnt=%b", k, if4.gnt);
    end
    req = '0; tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
